// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline sequencing controller for the 16-bit five-stage core.
//
// Drives write enables / synchronous clears of PC, IF/ID, ID/EX and EX/MEM.
// Resolves load-use hazards, taken branches, jumps, imem/dmem wait states and
// HALT (drain, halted, resume). Keeps saturating stall/flush event counters.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   id_rs/id_rt           source regs of ID instruction (+ id_use_rs/rt)
//   ex_memread, ex_rd     load in EX and its destination
//   ex_branch_taken       taken branch resolved in EX
//   id_jump, id_halt      jump / HALT decoded in ID
//   imem_ready, dmem_busy memory wait states
//   resume                leave HALTED
//   cnt_clr               clear both counters
//   wr_*, IFIDclear, IDEXclear, pc_sel, halted   pipeline control (Mealy)
//   stall_cnt, flush_cnt  saturating 16-bit event counters
module hazard_ctrl #(
  parameter int RW        = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_branch_taken,
  input  logic          id_jump,
  input  logic          id_halt,
  input  logic          imem_ready,
  input  logic          dmem_busy,
  input  logic          resume,
  input  logic          cnt_clr,
  output logic          wr_PC,
  output logic          wr_IFID,
  output logic          wr_IDEX,
  output logic          wr_EXMEM,
  output logic          IFIDclear,
  output logic          IDEXclear,
  output logic [1:0]    pc_sel,
  output logic          halted,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);

  state_t     state, state_nxt;
  logic [3:0] dcnt, dcnt_nxt;
  logic       hazard;
  logic       stall_inc, flush_inc;

  // r0 is hardwired, so a load targeting it never blocks the consumer.
  assign hazard = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    wr_PC     = 1'b1;
    wr_IFID   = 1'b1;
    wr_IDEX   = 1'b1;
    wr_EXMEM  = 1'b1;
    IFIDclear = 1'b0;
    IDEXclear = 1'b0;
    pc_sel    = 2'b00;
    halted    = 1'b0;
    state_nxt = state;
    dcnt_nxt  = dcnt;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    unique case (state)
      RUN: begin
        if (dmem_busy) begin
          // Full freeze: a taken branch stays presented by the held EX stage.
          {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM} = 4'b0000;
          stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
          // Squashes whatever sits in IF and ID, including halt/jump/hazard.
          pc_sel    = 2'b01;
          wr_IFID   = 1'b0;
          wr_IDEX   = 1'b0;
          IFIDclear = 1'b1;
          IDEXclear = 1'b1;
          flush_inc = 1'b1;
        end else if (hazard) begin
          wr_PC     = 1'b0;
          wr_IFID   = 1'b0;
          wr_IDEX   = 1'b0;
          IDEXclear = 1'b1;
          stall_inc = 1'b1;
        end else if (id_halt) begin
          // PC holds the address after HALT so resume restarts there.
          wr_PC     = 1'b0;
          wr_IFID   = 1'b0;
          IFIDclear = 1'b1;
          state_nxt = DRAIN;
          dcnt_nxt  = DRAIN_INIT;
        end else if (id_jump) begin
          pc_sel    = 2'b10;
          wr_IFID   = 1'b0;
          IFIDclear = 1'b1;
          flush_inc = 1'b1;
        end else if (!imem_ready) begin
          wr_PC     = 1'b0;
          wr_IFID   = 1'b0;
          IFIDclear = 1'b1;
          stall_inc = 1'b1;
        end
      end

      DRAIN: begin
        if (dmem_busy) begin
          // Frozen cycles do not count toward the drain.
          {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM} = 4'b0000;
          stall_inc = 1'b1;
        end else begin
          wr_PC     = 1'b0;
          wr_IFID   = 1'b0;
          IFIDclear = 1'b1;
          dcnt_nxt  = dcnt - 4'd1;
          if (dcnt == 4'd1) state_nxt = HALTED;
        end
      end

      HALTED: begin
        {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM} = 4'b0000;
        halted = 1'b1;
        if (resume) state_nxt = RUN;
      end

      default: state_nxt = RUN;
    endcase

    // In reset the pipeline registers are held empty.
    if (!reset) begin
      {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM} = 4'b0000;
      IFIDclear = 1'b1;
      IDEXclear = 1'b1;
      pc_sel    = 2'b00;
      halted    = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_inc && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl - directed bench for hazard_ctrl (RW=4, DRAIN_CYC=3).
// Expected control vectors are queued as each step is driven and popped at
// the following falling edge; counters are checked against a bench model.
module tb_hazard_ctrl;

  localparam int RW = 4;

  // {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, IFIDclear, IDEXclear, pc_sel, halted}
  localparam logic [8:0] DEF  = 9'b1111_00_00_0;
  localparam logic [8:0] FRZ  = 9'b0000_00_00_0;
  localparam logic [8:0] BR   = 9'b1001_11_01_0;
  localparam logic [8:0] HAZ  = 9'b0001_01_00_0;
  localparam logic [8:0] HOLD = 9'b0011_10_00_0;
  localparam logic [8:0] JMP  = 9'b1011_10_10_0;
  localparam logic [8:0] HLTD = 9'b0000_00_00_1;
  localparam logic [8:0] RST  = 9'b0000_11_00_0;

  typedef struct {
    logic [8:0] outs;
    logic       st_inc;
    logic       fl_inc;
    string      tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, ex_rd;
  logic          id_use_rs, id_use_rt, ex_memread, ex_branch_taken;
  logic          id_jump, id_halt, imem_ready, dmem_busy, resume, cnt_clr;
  logic          wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, IFIDclear, IDEXclear, halted;
  logic [1:0]    pc_sel;
  logic [15:0]   stall_cnt, flush_cnt;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_stall = '0;
  logic [15:0] m_flush = '0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RW(RW), .DRAIN_CYC(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .id_halt(id_halt), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy), .resume(resume), .cnt_clr(cnt_clr),
    .wr_PC(wr_PC), .wr_IFID(wr_IFID), .wr_IDEX(wr_IDEX), .wr_EXMEM(wr_EXMEM),
    .IFIDclear(IFIDclear), .IDEXclear(IDEXclear), .pc_sel(pc_sel),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [8:0] obs();
    return {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, IFIDclear, IDEXclear, pc_sel, halted};
  endfunction

  task automatic chk9(input string tag, input logic [8:0] o, input logic [8:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_memread = 0; ex_branch_taken = 0;
    id_jump = 0; id_halt = 0; imem_ready = 1; dmem_busy = 0; resume = 0; cnt_clr = 0;
  endtask

  // Inputs are already driven; queue the expectation, check at negedge,
  // then advance the counter model across the rising edge.
  task automatic step(input string tag, input logic [8:0] e, input logic si, input logic fi);
    exp_t x, y;
    x.outs = e; x.st_inc = si; x.fl_inc = fi; x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
    y = sb.pop_front();
    chk9({y.tag, "_outs"}, obs(), y.outs);
    chk16({y.tag, "_stall"}, stall_cnt, m_stall);
    chk16({y.tag, "_flush"}, flush_cnt, m_flush);
    @(posedge clk);
    if (!reset) begin
      m_stall = '0; m_flush = '0;
    end else if (cnt_clr) begin
      m_stall = '0; m_flush = '0;
    end else begin
      if (y.st_inc && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (y.fl_inc && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 0;
    step("reset", RST, 0, 0);
    reset = 1;
    step("idle", DEF, 0, 0);

    // load-use on rs, then the same with rd=r0
    ex_memread = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
    step("lu_rs", HAZ, 1, 0);
    step("lu_after", DEF, 0, 0);
    ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    step("lu_r0", DEF, 0, 0);
    ex_memread = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
    step("lu_rt", HAZ, 1, 0);
    ex_memread = 1; ex_rd = 5; id_rt = 5; id_use_rt = 0;
    step("lu_rt_unused", DEF, 0, 0);
    cnt_clr = 1;
    step("clr0", DEF, 0, 0);

    // branch beats halt in ID; state stays RUN
    ex_branch_taken = 1; id_halt = 1;
    step("br_vs_halt", BR, 0, 1);
    step("br_after", DEF, 0, 0);
    id_jump = 1;
    step("jump", JMP, 0, 1);
    resume = 1;
    step("resume_in_run", DEF, 0, 0);

    // halt drain with one freeze cycle: halted at T+5, RUN at T+8
    id_halt = 1;
    step("halt_T", HOLD, 0, 0);
    ex_branch_taken = 1; id_jump = 1;
    step("drain_T1", HOLD, 0, 0);
    dmem_busy = 1;
    step("drain_T2_busy", FRZ, 1, 0);
    imem_ready = 0;
    step("drain_T3", HOLD, 0, 0);
    step("drain_T4", HOLD, 0, 0);
    step("halted_T5", HLTD, 0, 0);
    id_halt = 1;
    step("halted_T6", HLTD, 0, 0);
    resume = 1;
    step("halted_T7", HLTD, 0, 0);
    step("run_T8", DEF, 0, 0);

    // freeze priority over branch
    cnt_clr = 1;
    step("clr1", DEF, 0, 0);
    dmem_busy = 1; ex_branch_taken = 1;
    step("frz1", FRZ, 1, 0);
    dmem_busy = 1; ex_branch_taken = 1;
    step("frz2", FRZ, 1, 0);
    ex_branch_taken = 1;
    step("frz_br", BR, 0, 1);
    step("frz_done", DEF, 0, 0);

    // imem wait
    cnt_clr = 1;
    step("clr2", DEF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 0;
      step("imem_wait", HOLD, 1, 0);
    end
    cnt_clr = 1; dmem_busy = 1;
    step("clr_vs_inc", FRZ, 1, 0);
    step("after_clr", DEF, 0, 0);

    // async reset mid-drain
    id_halt = 1;
    step("halt2", HOLD, 0, 0);
    step("drain2", HOLD, 0, 0);
    reset = 0;
    #1;
    chk9("async_rst_outs", obs(), RST);
    checks++;
    assert (halted === 1'b0) else begin
      errors++;
      $error("FAIL async_rst_halted: observed %b expected 0", halted);
    end
    m_stall = '0; m_flush = '0;
    step("in_reset", RST, 0, 0);
    reset = 1;
    step("run_after_rst", DEF, 0, 0);
    ex_memread = 1; ex_rd = 7; id_rs = 7; id_use_rs = 1;
    step("hazard_after_rst", HAZ, 1, 0);

    // stall counter saturation
    cnt_clr = 1;
    step("clr3", DEF, 0, 0);
    dmem_busy = 1;
    repeat (65535) @(posedge clk);
    #1;
    m_stall = 16'hFFFF;
    dmem_busy = 1;
    step("sat1", FRZ, 1, 0);
    dmem_busy = 1;
    step("sat2", FRZ, 1, 0);
    step("sat_end", DEF, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 16-bit five-stage core. It drives the write enables and synchronous clears of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken branches, jumps, instruction/data memory wait states and HALT, including halt drain and resume. It also keeps saturating stall and flush counters for performance debug.

## Interface
- RW, 4, register-specifier width
- DRAIN_CYC, 3, non-frozen cycles after HALT leaves ID before `halted` asserts (legal 1..15)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  RW  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  RW  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- id_jump  in  1  jump decoded in ID
- id_halt  in  1  HALT decoded in ID
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_busy  in  1  data memory access not complete
- resume  in  1  leave HALTED
- cnt_clr  in  1  synchronous clear of both counters
- wr_PC, wr_IFID, wr_IDEX, wr_EXMEM  out  1  register write enables
- IFIDclear, IDEXclear  out  1  bubble insertion; when a clear is 1 the matching wr_* is 0
- pc_sel  out  2  00 PC+1, 01 branch target, 10 jump target
- halted  out  1  core halted
- stall_cnt, flush_cnt  out  16  saturating event counters

## Operation
- Register 0 is hardwired: `ex_rd==0` never creates a hazard.
- hazard = ex_memread & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- State machine: RUN, DRAIN, HALTED. 4-bit drain counter `dcnt`.
- Outputs are combinational from state and inputs (Mealy). The default is all wr_*=1, clears 0, pc_sel=00.
- RUN priority (first match wins):
  1. dmem_busy: freeze. All wr_*=0, clears 0. stall_cnt++.
  2. ex_branch_taken: pc_sel=01, wr_PC=1, IFIDclear=1, IDEXclear=1, wr_EXMEM=1. flush_cnt++.
  3. hazard: wr_PC=0, wr_IFID=0, IDEXclear=1, wr_EXMEM=1. stall_cnt++.
  4. id_halt: wr_PC=0, IFIDclear=1, wr_IDEX=1, wr_EXMEM=1. Next state DRAIN, dcnt<=DRAIN_CYC.
  5. id_jump: pc_sel=10, wr_PC=1, IFIDclear=1, wr_IDEX=1, wr_EXMEM=1. flush_cnt++.
  6. !imem_ready: wr_PC=0, IFIDclear=1, wr_IDEX=1, wr_EXMEM=1. stall_cnt++.
- DRAIN:
  - wr_PC=0, IFIDclear=1, wr_IDEX=1, wr_EXMEM=1, dcnt--.
  - If dcnt==1, next state is HALTED.
  - dmem_busy overrides: full freeze, dcnt holds, stall_cnt++.
  - ex_branch_taken, hazard, id_jump, id_halt and imem_ready are ignored in DRAIN.
- HALTED:
  - All wr_*=0, clears 0, halted=1.
  - resume=1 moves to RUN next cycle. Fetch restarts from the held PC, i.e. the instruction after HALT.
- Counters:
  - Each counter increments by at most 1 per cycle and saturates at 16'hFFFF.
  - cnt_clr wins over increment; both counters read 0 the next cycle.

## Timing
- While reset=0:
  - State RUN, dcnt=0, counters 0, halted=0.
  - Outputs forced to all wr_*=0, IFIDclear=IDEXclear=1, pc_sel=00.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately (asynchronous).
- Latency:
  - Hazard, branch and jump outputs respond in the same cycle as their inputs. The controlled registers act at the next rising edge.
  - Load-use costs exactly 1 bubble, because the load then advances to MEM and hazard drops.
  - Taken branch costs 2 flushed slots; jump costs 1.
- Simultaneous events:
  - Branch in EX with halt/jump/hazard in ID: the branch wins, and the ID instruction is squashed.
  - dmem_busy with anything: freeze wins, and the branch stays presented by the held EX stage.
- HALT timing:
  - HALT in ID at cycle T with no freezes: DRAIN covers T+1..T+DRAIN_CYC.
  - halted=1 from T+DRAIN_CYC+1.
  - Each dmem_busy cycle during DRAIN delays halted by 1.
- resume and id_halt have no effect outside their states.

## Test plan
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_use_rs=1 for one cycle -> wr_PC=0, wr_IFID=0, IDEXclear=1 that cycle; stall_cnt 0->1. The same case with ex_rd=0 -> no stall.
- Branch vs halt: ex_branch_taken=1 and id_halt=1 together -> pc_sel=01, IFIDclear=IDEXclear=1; state stays RUN; flush_cnt=1.
- Halt drain, DRAIN_CYC=3: id_halt at T, dmem_busy high at T+2 -> halted rises at T+5. resume at T+7 -> RUN at T+8 with all wr_*=1.
- Freeze priority: dmem_busy=1 with ex_branch_taken=1 for 2 cycles, then busy drops -> 2 full-freeze cycles, then pc_sel=01 with clears; stall_cnt=2, flush_cnt=1.
- imem wait plus counters: imem_ready=0 for 3 cycles -> wr_PC=0, IFIDclear=1, wr_IDEX=1 each cycle; stall_cnt=3. cnt_clr -> 0. Preload stall_cnt to FFFF -> it stays FFFF.
- Async reset in DRAIN: assert reset mid-drain -> outputs forced immediately, halted=0; state RUN after release.
